move_sequencer: RTL and testbench

- Accepts Rubik's-cube face-turn commands one at a time over a valid/ready handshake.
- For each command, drives the matching one of six stepper_driver instances: one-cycle start pulse, direction, step count.
- Waits for that driver's done, then holds a settle interval before accepting the next move.
- Sits between the solution/move FIFO and the six face drivers; guarantees only one motor moves at a time.

---
 rtl/rbot_pkg.sv | 37 +++
 rtl/move_sequencer_if.sv | 33 +++
 rtl/interval_counter.sv | 38 +++
 rtl/move_sequencer.sv | 145 ++++++++++++++
 tb/tb_move_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rbot_pkg.sv
// rbot_pkg -- shared definitions for the cube-robot motion blocks.
//   Face index constants (U,D,F,B,L,R = 0..5), the move_sequencer state
//   encoding, default step counts for quarter and half turns, and a helper
//   that maps a face index to a one-hot driver select.
package rbot_pkg;

  localparam logic [2:0] FACE_U = 3'd0;
  localparam logic [2:0] FACE_D = 3'd1;
  localparam logic [2:0] FACE_F = 3'd2;
  localparam logic [2:0] FACE_B = 3'd3;
  localparam logic [2:0] FACE_L = 3'd4;
  localparam logic [2:0] FACE_R = 3'd5;
  localparam int         NUM_FACES = 6;

  localparam int DEF_QUARTER_STEPS = 50;
  localparam int DEF_HALF_STEPS    = 100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ARM    = 3'd2,
    S_WAIT   = 3'd3,
    S_SETTLE = 3'd4,
    S_HALT   = 3'd5
  } seq_state_e;

  // One-hot select for a face; illegal indices (6,7) select nothing.
  function automatic logic [NUM_FACES-1:0] face_onehot(input logic [2:0] face);
    logic [NUM_FACES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_FACES; i++) begin
      if (face == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// move_sequencer_if -- command and driver-side signals of the move sequencer.
//   cmd_valid/cmd_face/cmd_dir/cmd_half/cmd_ready : move command handshake
//   drv_start/drv_dir/drv_steps/drv_done          : six stepper drivers
//   busy/fault/moves_done                         : status
//   modport slave  : the sequencer itself
//   modport master : the surrounding system (move FIFO, drivers, status reader)
interface move_sequencer_if;
  import rbot_pkg::*;

  logic                 cmd_valid;
  logic [2:0]           cmd_face;
  logic                 cmd_dir;
  logic                 cmd_half;
  logic                 cmd_ready;
  logic [NUM_FACES-1:0] drv_start;
  logic                 drv_dir;
  logic [7:0]           drv_steps;
  logic [NUM_FACES-1:0] drv_done;
  logic                 busy;
  logic                 fault;
  logic [15:0]          moves_done;

  modport slave (
    input  cmd_valid, cmd_face, cmd_dir, cmd_half, drv_done,
    output cmd_ready, drv_start, drv_dir, drv_steps, busy, fault, moves_done
  );

  modport master (
    output cmd_valid, cmd_face, cmd_dir, cmd_half, drv_done,
    input  cmd_ready, drv_start, drv_dir, drv_steps, busy, fault, moves_done
  );

endinterface

// File: rtl/interval_counter.sv
// interval_counter -- loadable down-counter with a zero flag.
//   clock, reset_n : clock and synchronous active-low reset (count -> 0)
//   load, load_val : load the count (load wins over dec)
//   dec            : decrement by one; holds at zero
//   zero           : count is currently zero
module interval_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer -- issues one face turn at a time to six stepper drivers.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : command handshake in, driver start/dir/steps out,
//                    driver done in, busy/fault/moves_done status out
// A move is: accept -> START (one-cycle start pulse) -> ARM (done ignored
// while the driver clears its previous done) -> WAIT (for the selected
// driver's done, bounded by a timeout) -> SETTLE (fixed idle hold) -> IDLE.
// Timeouts and illegal faces park the block in HALT until reset.
// All outputs are registered.
module move_sequencer
  import rbot_pkg::*;
#(
  parameter int QUARTER_STEPS  = DEF_QUARTER_STEPS,
  parameter int HALF_STEPS     = DEF_HALF_STEPS,
  parameter int SETTLE_CYCLES  = 500000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input logic             clock,
  input logic             reset_n,
  move_sequencer_if.slave bus
);

  localparam int SETTLE_W  = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Counters are loaded with N-1 so that the zero flag marks the Nth cycle.
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD  = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]           QUARTER_CNT  = 8'(QUARTER_STEPS);
  localparam logic [7:0]           HALF_CNT     = 8'(HALF_STEPS);

  seq_state_e           state_q, state_d;
  logic [2:0]           face_q, face_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic [NUM_FACES-1:0] drv_start_q, drv_start_d;
  logic                 drv_dir_q, drv_dir_d;
  logic [7:0]           drv_steps_q, drv_steps_d;
  logic                 busy_q, busy_d;
  logic                 fault_q, fault_d;
  logic [15:0]          moves_done_q, moves_done_d;

  logic accept;
  logic face_legal;
  logic done_sel;
  logic settle_zero;
  logic timeout_zero;

  // cmd_ready_q is only ever high in IDLE without a fault.
  assign accept     = bus.cmd_valid & cmd_ready_q;
  assign face_legal = (bus.cmd_face <= FACE_R);
  // Only the active face's done matters; the others are don't-care.
  assign done_sel   = |(bus.drv_done & face_onehot(face_q));

  interval_counter #(.WIDTH(SETTLE_W)) u_settle (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     ((state_q == S_WAIT) && done_sel),
    .load_val (SETTLE_LOAD),
    .dec      (state_q == S_SETTLE),
    .zero     (settle_zero)
  );

  interval_counter #(.WIDTH(TIMEOUT_W)) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (state_q == S_ARM),
    .load_val (TIMEOUT_LOAD),
    .dec      ((state_q == S_WAIT) && !done_sel),
    .zero     (timeout_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      face_q       <= '0;
      cmd_ready_q  <= 1'b0;
      drv_start_q  <= '0;
      drv_dir_q    <= 1'b0;
      drv_steps_q  <= '0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      moves_done_q <= '0;
    end else begin
      state_q      <= state_d;
      face_q       <= face_d;
      cmd_ready_q  <= cmd_ready_d;
      drv_start_q  <= drv_start_d;
      drv_dir_q    <= drv_dir_d;
      drv_steps_q  <= drv_steps_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      moves_done_q <= moves_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = face_legal ? S_START : S_HALT;
      S_START:  state_d = S_ARM;
      S_ARM:    state_d = S_WAIT;
      S_WAIT: begin
        // Done wins over a timeout expiring in the same cycle.
        if (done_sel)          state_d = S_SETTLE;
        else if (timeout_zero) state_d = S_HALT;
      end
      S_SETTLE: if (settle_zero) state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so that each one
  // is valid in the same cycle as the state it belongs to.
  always_comb begin
    face_d       = face_q;
    drv_dir_d    = drv_dir_q;
    drv_steps_d  = drv_steps_q;
    moves_done_d = moves_done_q;

    if ((state_q == S_IDLE) && accept) begin
      face_d      = bus.cmd_face;
      drv_dir_d   = bus.cmd_dir;
      drv_steps_d = bus.cmd_half ? HALF_CNT : QUARTER_CNT;
    end

    if ((state_q == S_WAIT) && done_sel) begin
      moves_done_d = moves_done_q + 16'd1;
    end

    fault_d     = fault_q | (state_d == S_HALT);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE) && !fault_d;
    drv_start_d = (state_d == S_START) ? face_onehot(face_d) : '0;
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.drv_start  = drv_start_q;
  assign bus.drv_dir    = drv_dir_q;
  assign bus.drv_steps  = drv_steps_q;
  assign bus.busy       = busy_q;
  assign bus.fault      = fault_q;
  assign bus.moves_done = moves_done_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer -- directed bench for move_sequencer with an
// event-level reference model compared every cycle, plus literal checks.
module tb_move_sequencer;
  import rbot_pkg::*;

  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 100;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   start_cyc[$];

  move_sequencer_if bus();

  move_sequencer #(
    .QUARTER_STEPS (50),
    .HALF_STEPS    (100),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks where the current move is in cycles since
  // accept, and what every output must be after each clock edge.
  bit          cmp_en   = 1'b0;
  bit          m_moving = 1'b0;
  bit          m_halt   = 1'b0;
  int          m_age    = 0;
  int          m_settle = 0;
  int          m_face   = 0;
  logic [5:0]  e_start  = '0;
  logic        e_dir    = 1'b0;
  logic [7:0]  e_steps  = '0;
  logic        e_ready  = 1'b0;
  logic        e_busy   = 1'b0;
  logic        e_fault  = 1'b0;
  logic [15:0] e_moves  = '0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_moving = 0; m_halt = 0; m_age = 0; m_settle = 0; m_face = 0;
      e_start = '0; e_dir = 0; e_steps = '0; e_ready = 0; e_busy = 0;
      e_fault = 0; e_moves = '0; cmp_en = 1;
    end else if (cmp_en) begin
      e_start = '0;
      if (m_halt) begin
        e_ready = 0;
      end else if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin e_busy = 0; e_ready = 1; end
      end else if (m_moving) begin
        // age 0 = START, 1 = ARM, age k>=2 = WAIT cycle k-1
        if (m_age < 2) m_age++;
        else if (bus.drv_done[m_face]) begin
          e_moves++; m_moving = 0; m_settle = SETTLE;
        end else if (m_age - 1 == TIMEOUT) begin
          m_halt = 1; m_moving = 0; e_fault = 1;
        end else m_age++;
      end else if (e_ready && bus.cmd_valid) begin
        e_ready = 0; e_busy = 1; e_dir = bus.cmd_dir;
        e_steps = bus.cmd_half ? 8'd100 : 8'd50;
        if (bus.cmd_face > 3'd5) begin
          m_halt = 1; e_fault = 1;
        end else begin
          m_moving = 1; m_age = 0; m_face = int'(bus.cmd_face);
          e_start = 6'(1 << m_face);
        end
      end else begin
        e_ready = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("m_ready", 32'(bus.cmd_ready),  32'(e_ready));
      check("m_start", 32'(bus.drv_start),  32'(e_start));
      check("m_dir",   32'(bus.drv_dir),    32'(e_dir));
      check("m_steps", 32'(bus.drv_steps),  32'(e_steps));
      check("m_busy",  32'(bus.busy),       32'(e_busy));
      check("m_fault", 32'(bus.fault),      32'(e_fault));
      check("m_moves", 32'(bus.moves_done), 32'(e_moves));
    end
    if (bus.drv_start != '0) start_cyc.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 1000) begin
      tick(1);
      n++;
    end
    check({name, "_ready_bound"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  // Returns in the START cycle of the accepted command.
  task automatic send(input logic [2:0] f, input logic d, input logic h);
    bus.cmd_face  = f;
    bus.cmd_dir   = d;
    bus.cmd_half  = h;
    bus.cmd_valid = 1'b1;
    wait_ready("send");
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ready"}, 32'(bus.cmd_ready),  0);
    check({name, "_start"}, 32'(bus.drv_start),  0);
    check({name, "_dir"},   32'(bus.drv_dir),    0);
    check({name, "_steps"}, 32'(bus.drv_steps),  0);
    check({name, "_busy"},  32'(bus.busy),       0);
    check({name, "_fault"}, 32'(bus.fault),      0);
    check({name, "_moves"}, 32'(bus.moves_done), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    bus.cmd_valid = 1'b0;
    bus.cmd_face  = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_half  = 1'b0;
    bus.drv_done  = '0;

    tick(3);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // Quarter turn on F, clockwise; done 60 cycles after ARM begins.
    send(FACE_F, 1'b1, 1'b0);
    check("q_start", 32'(bus.drv_start), 32'h04);
    check("q_steps", 32'(bus.drv_steps), 50);
    check("q_dir",   32'(bus.drv_dir),   1);
    tick(1);
    check("q_start_off", 32'(bus.drv_start), 0);
    tick(60);
    bus.drv_done[FACE_F] = 1'b1;
    tick(1);
    bus.drv_done = '0;
    check("q_moves", 32'(bus.moves_done), 1);
    n = 0;
    while (!bus.cmd_ready && n < 100) begin tick(1); n++; end
    check("q_settle_len", n, SETTLE);

    // Half turn on R, ccw, with every other done held high.
    bus.drv_done = 6'b011111;
    send(FACE_R, 1'b0, 1'b1);
    check("h_start", 32'(bus.drv_start), 32'h20);
    check("h_steps", 32'(bus.drv_steps), 100);
    check("h_dir",   32'(bus.drv_dir),   0);
    tick(30);
    check("h_not_done", 32'(bus.moves_done), 1);
    check("h_busy",     32'(bus.busy),       1);
    bus.drv_done[FACE_R] = 1'b1;
    tick(1);
    bus.drv_done = '0;
    check("h_moves", 32'(bus.moves_done), 2);
    wait_ready("h");

    // Stale done through START and ARM, dropped, then a real rise.
    bus.drv_done[FACE_U] = 1'b1;
    send(FACE_U, 1'b1, 1'b1);
    tick(2);
    bus.drv_done = '0;
    tick(20);
    check("s_not_done", 32'(bus.moves_done), 2);
    bus.drv_done[FACE_U] = 1'b1;
    tick(1);
    bus.drv_done = '0;
    check("s_moves", 32'(bus.moves_done), 3);
    wait_ready("s");

    // Back-to-back: valid held high over three commands, done in WAIT cycle 3.
    n0 = start_cyc.size();
    bus.cmd_face  = FACE_D;
    bus.cmd_dir   = 1'b0;
    bus.cmd_half  = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [2:0] cur;
      cur = bus.cmd_face;
      wait_ready("b2b");
      tick(1);
      bus.cmd_face = (i == 0) ? FACE_B : FACE_L;
      if (i == 2) bus.cmd_valid = 1'b0;
      tick(4);
      bus.drv_done = face_onehot(cur);
      tick(1);
      bus.drv_done = '0;
    end
    wait_ready("b2b_end");
    check("b2b_moves",  32'(bus.moves_done), 6);
    check("b2b_pulses", start_cyc.size() - n0, 3);
    if (start_cyc.size() == n0 + 3) begin
      check("b2b_gap1", start_cyc[n0+1] - start_cyc[n0],   16);
      check("b2b_gap2", start_cyc[n0+2] - start_cyc[n0+1], 16);
    end

    // Timeout: driver never finishes.
    send(FACE_L, 1'b1, 1'b0);
    tick(1 + TIMEOUT);
    check("t_fault_pre", 32'(bus.fault), 0);
    tick(1);
    check("t_fault",  32'(bus.fault),     1);
    check("t_ready",  32'(bus.cmd_ready), 0);
    tick(5);
    check("t_ready_hold", 32'(bus.cmd_ready), 0);
    check("t_busy",       32'(bus.busy),      1);
    reset_n = 1'b0;
    tick(1);
    check_reset_vals("t_rst");
    reset_n = 1'b1;

    // Illegal face 7: fault, no start pulse.
    n0 = start_cyc.size();
    send(3'd7, 1'b1, 1'b0);
    check("i_fault", 32'(bus.fault),     1);
    check("i_start", 32'(bus.drv_start), 0);
    tick(5);
    check("i_no_pulse", start_cyc.size() - n0, 0);
    check("i_ready",    32'(bus.cmd_ready),    0);
    reset_n = 1'b0;
    tick(1);
    check_reset_vals("i_rst");
    reset_n = 1'b1;

    // Reset in the middle of WAIT, then a normal move.
    send(FACE_B, 1'b1, 1'b1);
    tick(12);
    reset_n = 1'b0;
    tick(1);
    check_reset_vals("w_rst");
    reset_n = 1'b1;
    send(FACE_L, 1'b0, 1'b1);
    check("w_start", 32'(bus.drv_start), 32'h10);
    check("w_steps", 32'(bus.drv_steps), 100);
    tick(3);
    bus.drv_done[FACE_L] = 1'b1;
    tick(1);
    bus.drv_done = '0;
    check("w_moves", 32'(bus.moves_done), 1);
    wait_ready("w");

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
